// File: rtl/wave_display_reader.sv
// Read side of the double-buffered waveform RAM: maps VGA pixels to sample fetches and
// produces a per-pixel draw flag two clocks later. WAVE_INTERP_EN draws connecting segments.
module wave_display_reader #(
    parameter int X_START = 256,
    parameter int Y_ROWS  = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        read_index,
    input  logic [7:0]  read_value,
    output logic [8:0]  read_address,
    output logic        wave_display_idle,
    output logic        pixel_valid,
    output logic        draw_pixel
);
    localparam logic [10:0] X_LO  = 11'(X_START);
    localparam logic [10:0] X_HI  = 11'(X_START + 512);
    localparam logic [9:0]  Y_LIM = 10'(Y_ROWS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_frame_start;
    logic        r_bank;

    logic        w_in_window;
    logic [7:0]  w_idx;

    logic [8:0]  r_addr;
    logic        r_s1_valid;
    logic        r_s1_win;
    logic [7:0]  r_s1_row;

    logic [7:0]  w_row_target;
    logic        w_hit;

    logic        r_s2_win;
    logic        r_pixel_valid;
    logic        r_draw;
    logic        r_idle;

    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid && (x == 11'd0) && (y == 10'd0)) begin
                    w_state_next  = S_DRAW;
                    w_frame_start = 1'b1;
                end
            end
            S_DRAW: begin
                if (valid && (y >= Y_LIM)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The bank is captured only at frame start, so a writer swap never tears a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_bank  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_frame_start) begin
                r_bank <= read_index;
            end
        end
    end

    assign w_in_window = valid && (r_state == S_DRAW) && (x >= X_LO) && (x < X_HI) && (y < Y_LIM);
    assign w_idx       = 8'((x - X_LO) >> 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= 9'd0;
            r_s1_valid <= 1'b0;
            r_s1_win   <= 1'b0;
            r_s1_row   <= 8'd0;
        end else begin
            r_s1_valid <= valid;
            r_s1_win   <= w_in_window;
            r_s1_row   <= y[8:1];
            if (w_in_window) begin
                r_addr <= {r_bank, w_idx};
            end
        end
    end

    assign w_row_target = 8'd255 - read_value;

`ifdef WAVE_INTERP_EN
    logic       r_s1_chg;
    logic [7:0] r_prev;
    logic [7:0] w_prev_target;
    logic [7:0] w_lo;
    logic [7:0] w_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_chg <= 1'b0;
            r_prev   <= 8'h80;
        end else begin
            r_s1_chg <= (w_idx != r_addr[7:0]);
            if (w_frame_start) begin
                r_prev <= 8'h80;
            end else if (r_s1_win && r_s1_chg) begin
                r_prev <= read_value;
            end
        end
    end

    assign w_prev_target = 8'd255 - r_prev;
    assign w_lo  = (w_prev_target < w_row_target) ? w_prev_target : w_row_target;
    assign w_hi  = (w_prev_target < w_row_target) ? w_row_target : w_prev_target;
    assign w_hit = (r_s1_row >= w_lo) && (r_s1_row <= w_hi);
`else
    assign w_hit = (r_s1_row == w_row_target);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_win      <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_draw        <= 1'b0;
            r_idle        <= 1'b1;
        end else begin
            r_s2_win      <= r_s1_win;
            r_pixel_valid <= r_s1_valid;
            r_draw        <= r_s1_win && w_hit;
            r_idle        <= (r_state == S_IDLE) && !r_s1_win && !r_s2_win;
        end
    end

    assign read_address      = r_addr;
    assign wave_display_idle = r_idle;
    assign pixel_valid       = r_pixel_valid;
    assign draw_pixel        = r_draw;
endmodule

// File: tb/tb_wave_display_reader.sv
// Bench for wave_display_reader: directed pixel scans against a frame-level model of the
// waveform renderer, plus literal expectations. Honours WAVE_INTERP_EN like the design.
module tb_wave_display_reader;
    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [10:0] x;
    logic [9:0]  y;
    logic        read_index;
    logic [7:0]  read_value;
    logic [8:0]  read_address;
    logic        wave_display_idle;
    logic        pixel_valid;
    logic        draw_pixel;

    logic [7:0]  mem [0:511];

    int checks   = 0;
    int failures = 0;

    wave_display_reader #(.X_START(256), .Y_ROWS(512)) dut (
        .clk               (clk),
        .reset             (rst_n),
        .valid             (valid),
        .x                 (x),
        .y                 (y),
        .read_index        (read_index),
        .read_value        (read_value),
        .read_address      (read_address),
        .wave_display_idle (wave_display_idle),
        .pixel_valid       (pixel_valid),
        .draw_pixel        (draw_pixel)
    );

    // Asynchronous-read RAM: data follows the registered address within the same cycle.
    assign read_value = mem[read_address];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: what the screen must show, pixel by pixel.
    bit         m_on;
    logic       m_bank;
    logic [7:0] m_prev;
    logic [7:0] m_last_idx;
    int         m_addr;
    bit         wd1, wd2, pend_pv, pend_draw;
    bit         exp_pv, exp_draw, exp_idle;
    bit         h1_v, h2_v;
    int         h1_x, h2_x;

    initial begin
        bit         win, hit;
        logic [7:0] idx, cur;
        int         row, rt, pt, lo, hi;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_on = 0; m_bank = 0; m_prev = 8'h80; m_last_idx = 0; m_addr = 0;
                wd1 = 0; wd2 = 0; pend_pv = 0; pend_draw = 0;
                exp_pv = 0; exp_draw = 0; exp_idle = 1;
            end else begin
                win = valid && m_on && (x >= 256) && (x < 768) && (y < 512);
                idx = 8'((int'(x) - 256) / 2);
                cur = mem[{m_bank, idx}];
                row = (int'(y) / 2) % 256;
                rt  = 255 - int'(cur);
                pt  = 255 - int'(m_prev);
`ifdef WAVE_INTERP_EN
                lo  = (rt < pt) ? rt : pt;
                hi  = (rt < pt) ? pt : rt;
                hit = (row >= lo) && (row <= hi);
`else
                lo  = rt;
                hi  = rt;
                hit = (row == rt);
`endif
                exp_pv    = pend_pv;
                exp_draw  = pend_draw;
                pend_pv   = valid;
                pend_draw = win && hit;
                exp_idle  = !m_on && !wd1 && !wd2;
                wd2 = wd1;
                wd1 = win;
                if (win) begin
                    m_addr = int'({m_bank, idx});
                    if (idx != m_last_idx) m_prev = cur;
                    m_last_idx = idx;
                end
                if (!m_on && valid && x == 0 && y == 0) begin
                    m_on = 1; m_bank = read_index; m_prev = 8'h80;
                end else if (m_on && valid && y >= 512) begin
                    m_on = 0;
                end
            end
            h2_v = h1_v; h2_x = h1_x;
            h1_v = valid; h1_x = int'(x);
        end
    end

    // Per-scan statistics on drawn pixels, attributed to the pixel two clocks back.
    int st_cnt, st_first, st_last, st_col;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("pixel_valid", int'(pixel_valid), int'(exp_pv));
                chk("draw_pixel", int'(draw_pixel), int'(exp_draw));
                chk("idle", int'(wave_display_idle), int'(exp_idle));
                chk("read_address", int'(read_address), m_addr);
                if (h2_v && draw_pixel && (st_col < 0 || st_col == h2_x)) begin
                    st_cnt++;
                    if (st_first < 0) st_first = h2_x;
                    st_last = h2_x;
                end
            end
        end
    end

    task automatic drive(input bit v, input int xx, input int yy);
        valid = v;
        x = 11'(xx);
        y = 10'(yy);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats(input int col);
        st_cnt = 0; st_first = -1; st_last = -1; st_col = col;
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) drive(0, 0, 0);
    endtask

    task automatic scan_row(input int yy, input int x0, input int x1);
        clear_stats(-1);
        for (int xx = x0; xx <= x1; xx++) drive(1, xx, yy);
        flush();
    endtask

    initial begin
        valid = 0; x = 0; y = 0; read_index = 0; rst_n = 1;
        clear_stats(-1);
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'd205;
            mem[256 + i] = 8'h80;
        end
        #3 rst_n = 0;
        #1;
        chk("rst_idle", int'(wave_display_idle), 1);
        chk("rst_pv", int'(pixel_valid), 0);
        chk("rst_draw", int'(draw_pixel), 0);
        chk("rst_addr", int'(read_address), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        drive(0, 0, 0);

        // Frame A, bank 0 = 205 -> row target 50 -> y=100 draws across the window.
        read_index = 0;
        drive(1, 0, 0);
        scan_row(100, 256, 767);
        chk("row100_count", st_cnt, 512);
        for (int xx = 256; xx < 276; xx++) drive(1, xx, 100);
        #1 rst_n = 0; valid = 0;
        #1;
        chk("midrst_idle", int'(wave_display_idle), 1);
        chk("midrst_draw", int'(draw_pixel), 0);
        chk("midrst_addr", int'(read_address), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        drive(0, 0, 0);
        scan_row(100, 256, 767);
        chk("after_rst_count", st_cnt, 0);
        chk("after_rst_idle", int'(wave_display_idle), 1);

        // Frame B, bank 1 = 0x80 -> row target 127 -> y=254,255.
        read_index = 1;
        drive(1, 0, 0);
        scan_row(254, 250, 775);
        chk("row254_count", st_cnt, 512);
        chk("row254_first", st_first, 256);
        chk("row254_last", st_last, 767);
        scan_row(252, 250, 775);
        chk("row252_count", st_cnt, 0);
        scan_row(256, 250, 775);
        chk("row256_count", st_cnt, 0);
        read_index = 0;
        scan_row(50, 256, 600);
        chk("bank_frozen", int'(read_address[8]), 1);
        drive(1, 767, 511);
        drive(1, 0, 512);
        chk("end_idle_k1", int'(wave_display_idle), 0);
        drive(0, 0, 0);
        chk("end_idle_k2", int'(wave_display_idle), 0);
        drive(0, 0, 0);
        chk("end_idle_k3", int'(wave_display_idle), 1);
        for (int i = 0; i < 4; i++) drive(1, 300, 600);
        chk("idle_hold", int'(wave_display_idle), 1);

        // Frame C, bank 0 ramp: addresses step every second column and hold past the window.
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        drive(1, 0, 0);
        chk("start_idle_m", int'(wave_display_idle), 1);
        drive(1, 1, 0);
        chk("start_idle_m1", int'(wave_display_idle), 0);
        for (int xx = 256; xx <= 768; xx++) begin
            drive(1, xx, 0);
            chk("ramp_addr", int'(read_address[7:0]), (xx >= 768) ? 255 : (xx - 256) / 2);
        end
        chk("ramp_bank", int'(read_address[8]), 0);
        drive(1, 769, 0);
        chk("ramp_hold", int'(read_address), 255);
        flush();
        drive(1, 0, 512);
        flush();

        // Frame D: sample 10 = 0x00, sample 11 = 0xFF; watch column 278 (first of sample 11).
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
        mem[10] = 8'h00;
        mem[11] = 8'hFF;
        drive(1, 0, 0);
        clear_stats(278);
        for (int yy = 0; yy < 512; yy++) begin
            drive(1, 276, yy);
            drive(1, 277, yy);
            drive(1, 278, yy);
        end
        flush();
`ifdef WAVE_INTERP_EN
        chk("col278_count", st_cnt, 512);
`else
        chk("col278_count", st_cnt, 2);
`endif
        chk("col278_first_row_draw", st_first, 278);
        drive(1, 0, 512);
        flush();
        chk("final_idle", int'(wave_display_idle), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
